// File: rtl/judge_banner.sv
`timescale 1ns/1ps
// judge_banner
//   Registered, timed judgement banner. A judgement strobe latches the message
//   (PERFECT / GOOD / OK / MISS) and renders it as a 7-row 5x7 dot-matrix bitmap
//   centred in CHARS character slots. The bitmap is held steady for HOLD_CYCLES,
//   then blinks BLINK_COUNT off/on pairs of BLINK_HALF cycles per half, and then
//   blanks itself.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   judge_valid  one-cycle strobe: new judgement on judge
//   judge        1=PERFECT 2=GOOD 3=OK 4=MISS, other codes ignored
//   clear        synchronous blank request
//   rows         row r (0 = top) at [r*CHARS*COL_W +: CHARS*COL_W]; slot k of a
//                row at [k*COL_W +: COL_W]; pixel column c at bit c of the slot
//   active       high while the banner is showing or blinking
//   cur_msg      latched judgement code, 0 when idle
//   done         one-cycle pulse when the display expires on its own
module judge_banner #(
  parameter int CHARS       = 7,
  parameter int COL_W       = 7,
  parameter int HOLD_CYCLES = 25000000,
  parameter int BLINK_HALF  = 6250000,
  parameter int BLINK_COUNT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       judge_valid,
  input  logic [2:0]                 judge,
  input  logic                       clear,
  output logic [7*CHARS*COL_W-1:0]   rows,
  output logic                       active,
  output logic [2:0]                 cur_msg,
  output logic                       done
);

  localparam int ROW_W = CHARS * COL_W;
  localparam int BM_W  = 7 * ROW_W;
  localparam int MAX_C = (HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF;
  localparam int CW    = $clog2(MAX_C) + 1;
  localparam int PW    = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) + 1 : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BLINK_HALF - 1);
  localparam logic [PW-1:0] PAIR_LAST = PW'((BLINK_COUNT > 0) ? BLINK_COUNT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHOW, BLINK} state_e;

  typedef enum logic [3:0] {
    G_BLANK, G_P, G_E, G_R, G_F, G_C, G_T, G_G, G_O, G_D, G_K, G_M, G_I, G_S
  } glyph_e;

  // 5x7 font, top row in the most significant 5 bits; within a row the MSB is
  // the leftmost pixel on screen.
  localparam logic [34:0] FONT [14] = '{
    35'b00000_00000_00000_00000_00000_00000_00000, // blank
    35'b11110_10001_10001_11110_10000_10000_10000, // P
    35'b11111_10000_10000_11110_10000_10000_11111, // E
    35'b11110_10001_10001_11110_10100_10010_10001, // R
    35'b11111_10000_10000_11110_10000_10000_10000, // F
    35'b01110_10001_10000_10000_10000_10001_01110, // C
    35'b11111_00100_00100_00100_00100_00100_00100, // T
    35'b01110_10001_10000_10111_10001_10001_01111, // G
    35'b01110_10001_10001_10001_10001_10001_01110, // O
    35'b11100_10010_10001_10001_10001_10010_11100, // D
    35'b10001_10010_10100_11000_10100_10010_10001, // K
    35'b10001_11011_10101_10101_10001_10001_10001, // M
    35'b01110_00100_00100_00100_00100_00100_01110, // I
    35'b01111_10000_10000_01110_00001_00001_11110  // S
  };

  function automatic int msg_len(input logic [2:0] code);
    case (code)
      3'd1:    return 7;
      3'd2:    return 4;
      3'd3:    return 2;
      3'd4:    return 4;
      default: return 0;
    endcase
  endfunction

  // Message text, first character in the top nibble.
  function automatic logic [27:0] msg_text(input logic [2:0] code);
    case (code)
      3'd1:    return {G_P, G_E, G_R, G_F, G_E, G_C, G_T};
      3'd2:    return {G_G, G_O, G_O, G_D, G_BLANK, G_BLANK, G_BLANK};
      3'd3:    return {G_O, G_K, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK};
      3'd4:    return {G_M, G_I, G_S, G_S, G_BLANK, G_BLANK, G_BLANK};
      default: return '0;
    endcase
  endfunction

  // Full bitmap for a code: message centred at slot (CHARS-L+1)/2, glyph pixels
  // in columns 1..5 of each slot, every other bit blank.
  function automatic logic [BM_W-1:0] render(input logic [2:0] code);
    logic [BM_W-1:0] bm;
    logic [27:0]     txt;
    logic [34:0]     glyph;
    logic [4:0]      px;
    int              len;
    int              start;
    bm    = '0;
    txt   = msg_text(code);
    len   = msg_len(code);
    start = (CHARS - len + 1) / 2;
    for (int i = 0; i < len; i++) begin
      glyph = FONT[glyph_e'(txt[27-4*i -: 4])];
      for (int r = 0; r < 7; r++) begin
        px = glyph[34-5*r -: 5];
        for (int j = 0; j < 5; j++) begin
          bm[r*ROW_W + (start+i)*COL_W + j + 1] = px[4-j];
        end
      end
    end
    return bm;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_q, phase_d;   // blink half: 0 = off, 1 = on
  logic [PW-1:0]   pairs_q, pairs_d;
  logic [2:0]      msg_d;
  logic            expire;
  logic            code_ok;
  logic [BM_W-1:0] rows_d;
  logic            active_d;

  assign code_ok = (judge != 3'd0) && (judge <= 3'd4);

  // State register. Outputs are registered here too, from their next values.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      pairs_q <= '0;
      cur_msg <= '0;
      rows    <= '0;
      active  <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pairs_q <= pairs_d;
      cur_msg <= msg_d;
      rows    <= rows_d;
      active  <= active_d;
      done    <= expire;
    end
  end

  // Next state. Priority: valid judgement, then clear, then timer expiry.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    pairs_d = pairs_q;
    msg_d   = cur_msg;
    expire  = 1'b0;

    if (judge_valid && code_ok) begin
      state_d = SHOW;
      cnt_d   = '0;
      phase_d = 1'b0;
      pairs_d = '0;
      msg_d   = judge;
    end else if (clear && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      phase_d = 1'b0;
      pairs_d = '0;
      msg_d   = '0;
    end else begin
      case (state_q)
        SHOW: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            phase_d = 1'b0;
            pairs_d = '0;
            if (BLINK_COUNT == 0) begin
              state_d = IDLE;
              msg_d   = '0;
              expire  = 1'b1;
            end else begin
              state_d = BLINK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BLINK: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            if (!phase_q) begin
              phase_d = 1'b1;
            end else if (pairs_q == PAIR_LAST) begin
              state_d = IDLE;
              phase_d = 1'b0;
              pairs_d = '0;
              msg_d   = '0;
              expire  = 1'b1;
            end else begin
              phase_d = 1'b0;
              pairs_d = pairs_q + PW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs derived from the next state so they line up with it after the edge.
  always_comb begin
    active_d = (state_d != IDLE);
    if (state_d == SHOW || (state_d == BLINK && phase_d)) begin
      rows_d = render(msg_d);
    end else begin
      rows_d = '0;
    end
  end

endmodule
